// File: rtl/dbus_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dbus_mem_responder_pkg
//   Shared types and constants for the LSU data-bus responder:
//     - responder FSM state encoding
//     - wait-state counter width
//     - access-fault code the LSU maps to load/store access-fault exceptions
//     - latched request record and the address-window helper
// ----------------------------------------------------------------------------
package dbus_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } type_dbus_resp_state_e;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int DBUS_WAIT_W = 4;

    // Byte lanes per 32-bit data word.
    localparam int DBUS_LANES = 4;

    // Fault cause reported alongside err_o; the LSU turns this into a
    // load- or store-access-fault depending on the access type.
    localparam logic [3:0] DBUS_ACCESS_FAULT = 4'd5;

    // Request fields captured when IDLE accepts an access.
    typedef struct packed {
        logic                  w_en;
        logic                  in_range;
        logic [31:0]           w_data;
        logic [DBUS_LANES-1:0] sel;
    } dbus_req_t;

    // offs is (addr - base) computed modulo 2^32, so addresses below the
    // base wrap to large values and fall outside the window naturally.
    function automatic logic dbus_in_window(input logic [31:0] offs,
                                            input logic [32:0] span);
        return ({1'b0, offs} < span);
    endfunction

endpackage

// File: rtl/dbus_sram_bank.sv
// ----------------------------------------------------------------------------
// dbus_sram_bank
//   Single-port synchronous SRAM, DEPTH_WORDS x 32, per-byte write enables,
//   registered read. No reset on the array or the read register.
//
//   clk     in   clock
//   re      in   read strobe; r_data captures mem[addr] on the edge
//   we      in   per-lane write enables
//   addr    in   word index
//   w_data  in   write data, lane-aligned
//   r_data  out  registered read data
// ----------------------------------------------------------------------------
module dbus_sram_bank
    import dbus_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [DBUS_LANES-1:0] we,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           w_data,
    output logic [31:0]           r_data
);

    logic [DBUS_LANES-1:0][7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < DBUS_LANES; b++) begin
            if (we[b]) mem[addr][b] <= w_data[8*b +: 8];
        end
        if (re) r_data <= mem[addr];
    end

endmodule

// File: rtl/dbus_mem_responder.sv
// ----------------------------------------------------------------------------
// dbus_mem_responder
//   Responder end of the LSU data bus. Accepts one load/store at a time,
//   waits WAIT_CYCLES, then acks for one cycle with read data or a fault.
//   Backed by dbus_sram_bank.
//
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   req_i        in   request valid, held with stable fields until ack_o
//   w_en_i       in   1 = store, 0 = load
//   addr_i       in   byte address
//   w_data_i     in   store data, lane-aligned
//   sel_byte_i   in   store byte enables
//   lsu_flush_i  in   abort the access (IDLE with req, or WAIT)
//   r_data_o     out  load word, non-zero only in the ack cycle
//   ack_o        out  one-cycle completion pulse
//   err_o        out  out-of-window fault, only in the ack cycle
// ----------------------------------------------------------------------------
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  w_en_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           w_data_i,
    input  logic [DBUS_LANES-1:0] sel_byte_i,
    input  logic                  lsu_flush_i,
    output logic [31:0]           r_data_o,
    output logic                  ack_o,
    output logic                  err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    type_dbus_resp_state_e  state, state_nxt;
    logic [DBUS_WAIT_W-1:0] cnt, cnt_nxt;

    dbus_req_t              req_in, req_q, req_cur;
    logic [AW-1:0]          widx_in, widx_q, widx_cur;
    logic [31:0]            offs;
    logic                   latch;
    logic                   go_resp;

    logic [DBUS_LANES-1:0]  ram_we;
    logic                   ram_re;
    logic [31:0]            ram_rdata;

    // ---------------- address decode on the live request ----------------
    assign offs    = addr_i - BASE_ADDR;
    assign widx_in = offs[2 +: AW];

    always_comb begin
        req_in          = '0;
        req_in.w_en     = w_en_i;
        req_in.in_range = dbus_in_window(offs, 33'(DEPTH_WORDS) * 33'd4);
        req_in.w_data   = w_data_i;
        req_in.sel      = sel_byte_i;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            req_q  <= '0;
            widx_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                req_q  <= req_in;
                widx_q <= widx_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        go_resp   = 1'b0;
        case (state)
            IDLE: begin
                // flush in the same cycle drops the request outright
                if (req_i && !lsu_flush_i) begin
                    latch   = 1'b1;
                    cnt_nxt = DBUS_WAIT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lsu_flush_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == DBUS_WAIT_W'(1)) begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- SRAM access on the edge entering RESP ----------------
    // With zero wait states that edge is also the accept edge, so the access
    // is steered from the live inputs while in IDLE.
    assign req_cur  = (state == IDLE) ? req_in  : req_q;
    assign widx_cur = (state == IDLE) ? widx_in : widx_q;

    // rst gating keeps an edge seen during reset from touching the array.
    always_comb begin
        ram_we = '0;
        ram_re = 1'b0;
        if (go_resp && !rst && req_cur.in_range) begin
            if (req_cur.w_en) ram_we = req_cur.sel;
            else              ram_re = 1'b1;
        end
    end

    dbus_sram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk    (clk),
        .re     (ram_re),
        .we     (ram_we),
        .addr   (widx_cur),
        .w_data (req_cur.w_data),
        .r_data (ram_rdata)
    );

    // ---------------- response ----------------
    assign ack_o    = (state == RESP);
    assign err_o    = (state == RESP) && !req_q.in_range;
    assign r_data_o = ((state == RESP) && !req_q.w_en && req_q.in_range) ? ram_rdata : '0;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Two responders share clk/rst: index 0 has one wait state, index 1 has none.
module tb_dbus_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [2];
    logic        we    [2];
    logic        flush [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [3:0]  sel   [2];
    logic [31:0] rd    [2];
    logic        ack   [2];
    logic        err   [2];

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] sb0 [$];
    logic [32:0] sb1 [$];
    logic [32:0] e0, e1;

    always #5 clk = ~clk;

    dbus_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) u_w1 (
        .clk(clk), .rst(rst), .req_i(req[0]), .w_en_i(we[0]), .addr_i(addr[0]),
        .w_data_i(wd[0]), .sel_byte_i(sel[0]), .lsu_flush_i(flush[0]),
        .r_data_o(rd[0]), .ack_o(ack[0]), .err_o(err[0]));

    dbus_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_w0 (
        .clk(clk), .rst(rst), .req_i(req[1]), .w_en_i(we[1]), .addr_i(addr[1]),
        .w_data_i(wd[1]), .sel_byte_i(sel[1]), .lsu_flush_i(flush[1]),
        .r_data_o(rd[1]), .ack_o(ack[1]), .err_o(err[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboards: every ack pops the expected {r_data, err} of its access.
    always @(negedge clk) begin
        if (ack[0] === 1'b1) begin
            if (sb0.size() == 0) begin
                vectors++; miscompares++;
                $error("FAIL w1_unexpected_ack observed=ack expected=no_ack");
            end else begin
                e0 = sb0.pop_front();
                chk("w1_rdata", rd[0], e0[32:1]);
                chk("w1_err", 32'(err[0]), 32'(e0[0]));
            end
        end
    end

    always @(negedge clk) begin
        if (ack[1] === 1'b1) begin
            if (sb1.size() == 0) begin
                vectors++; miscompares++;
                $error("FAIL w0_unexpected_ack observed=ack expected=no_ack");
            end else begin
                e1 = sb1.pop_front();
                chk("w0_rdata", rd[1], e1[32:1]);
                chk("w0_err", 32'(err[1]), 32'(e1[0]));
            end
        end
    end

    // One access on responder d; checks ack latency and that ack is a single pulse.
    task automatic acc(input int d, input logic w, input logic [31:0] a, input logic [31:0] data,
                       input logic [3:0] s, input logic [31:0] exp_d, input logic exp_e,
                       input logic flush_resp);
        int lat;
        int got;
        lat = (d == 0) ? 2 : 1;
        got = 0;
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addr[d] = a; wd[d] = data; sel[d] = s;
        if (d == 0) sb0.push_back({exp_d, exp_e}); else sb1.push_back({exp_d, exp_e});
        for (int k = 1; k <= 10 && got == 0; k++) begin
            @(posedge clk); #1;
            if (flush_resp && k == lat) flush[d] = 1'b1;
            @(negedge clk);
            if (ack[d] === 1'b1) begin
                got = k;
                chk("ack_latency", 32'(k), 32'(lat));
            end
        end
        if (got == 0) begin
            vectors++; miscompares++;
            $error("FAIL ack_timeout observed=none expected=ack");
        end
        @(posedge clk); #1;
        req[d] = 1'b0; flush[d] = 1'b0;
        @(negedge clk);
        chk("ack_single_pulse", 32'(ack[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; we[d] = 0; flush[d] = 0; addr[d] = 0; wd[d] = 0; sel[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ack", 32'(ack[d]), 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_rdata", rd[d], 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // ---- one wait state: basic store/load, partial store ----
        acc(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
        acc(0, 0, 32'h8000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        acc(0, 1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0, 1'b0);
        acc(0, 0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_ABEF, 1'b0, 1'b0);

        // ---- window edges: the out-of-range addresses alias words 0 and 15 ----
        acc(0, 1, 32'h8000_0000, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b0);
        acc(0, 1, 32'h8000_003C, 32'h2222_2222, 4'hF, 32'h0, 1'b0, 1'b0);
        acc(0, 0, 32'h7FFF_FFFC, 32'h0,         4'hF, 32'h0, 1'b1, 1'b0);
        acc(0, 0, BASE + DEPTH*4, 32'h0,        4'hF, 32'h0, 1'b1, 1'b0);
        acc(0, 1, BASE + DEPTH*4, 32'hBAD0_BAD0, 4'hF, 32'h0, 1'b1, 1'b0);
        acc(0, 1, 32'h7FFF_FFFC, 32'hBAD1_BAD1, 4'hF, 32'h0, 1'b1, 1'b0);
        acc(0, 0, 32'h8000_0000, 32'h0,         4'hF, 32'h1111_1111, 1'b0, 1'b0);
        acc(0, 0, 32'h8000_003C, 32'h0,         4'hF, 32'h2222_2222, 1'b0, 1'b0);

        // ---- flush in WAIT aborts the store ----
        @(posedge clk); #1;
        req[0] = 1; we[0] = 1; addr[0] = 32'h8000_0010; wd[0] = 32'hCAFE_F00D; sel[0] = 4'hF;
        @(posedge clk); #1;
        req[0] = 0; flush[0] = 1;
        @(posedge clk); #1;
        flush[0] = 0;
        repeat (3) begin
            @(negedge clk);
            chk("flush_wait_no_ack", 32'(ack[0]), 32'd0);
        end
        // ---- flush with a new request in IDLE drops it ----
        @(posedge clk); #1;
        req[0] = 1; we[0] = 1; addr[0] = 32'h8000_0010; wd[0] = 32'h7777_7777; flush[0] = 1;
        @(posedge clk); #1;
        req[0] = 0; flush[0] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("flush_idle_no_ack", 32'(ack[0]), 32'd0);
        end
        acc(0, 0, 32'h8000_0010, 32'h0, 4'hF, 32'hDEAD_ABEF, 1'b0, 1'b0);

        // ---- flush in RESP has no effect ----
        acc(0, 1, 32'h8000_0010, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, 1'b1);
        acc(0, 0, 32'h8000_0010, 32'h0, 4'hF, 32'h5555_AAAA, 1'b0, 1'b0);

        // ---- reset in WAIT: no ack, store not committed ----
        @(posedge clk); #1;
        req[0] = 1; we[0] = 1; addr[0] = 32'h8000_0010; wd[0] = 32'h0BAD_F00D; sel[0] = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", 32'(ack[0]), 32'd0);
        req[0] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_ack", 32'(ack[0]), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b0;
        acc(0, 0, 32'h8000_0010, 32'h0, 4'hF, 32'h5555_AAAA, 1'b0, 1'b0);

        // ---- zero wait states: preload, then four loads with req held high ----
        for (int i = 0; i < 4; i++)
            acc(1, 1, BASE + 32'(4*i), 32'hA5A5_0000 + 32'(i*17), 4'hF, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        req[1] = 1; we[1] = 0;
        for (int i = 0; i < 4; i++) begin
            addr[1] = BASE + 32'(4*i);
            sb1.push_back({32'hA5A5_0000 + 32'(i*17), 1'b0});
            @(negedge clk);
            chk("b2b_gap", 32'(ack[1]), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("b2b_ack", 32'(ack[1]), 32'd1);
            @(posedge clk); #1;
        end
        req[1] = 0;
        @(negedge clk);
        chk("b2b_end", 32'(ack[1]), 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_w1_drained", 32'(sb0.size()), 32'd0);
        chk("sb_w0_drained", 32'(sb1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
